// File: rtl/sync_fifo_modport.sv
// Single-clock FIFO with registered read data, programmable almost-full and
// almost-empty thresholds, and one-cycle overflow/underflow pulses.
// hw_rst clears the control state asynchronously. sw_rst clears the same
// state synchronously and takes priority over any write or read in that cycle.
// Storage contents are never cleared by either reset.

module sync_fifo_modport #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              hw_rst,
    input  logic              sw_rst,
    input  logic              top_wr_en,
    input  logic [DATA_W-1:0] top_wr_data,
    input  logic              top_rd_en,
    output logic [DATA_W-1:0] top_rd_data,
    input  logic [31:0]       almost_full_value,
    input  logic [31:0]       almost_empty_value,
    output logic              enq_fifo_full,
    output logic              valid,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              ext_mem_full,
    output logic              ext_mem_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wrPtr_q, wrPtr_d;
    logic [AW-1:0]     rdPtr_q, rdPtr_d;
    logic [AW:0]       count_q, count_d;
    logic [DATA_W-1:0] rdData_q, rdData_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic isFull;
    logic isEmpty;
    logic rdAccept;
    logic wrAccept;

    // Occupancy flags come straight from the registered count.
    // A read is never served from an incoming write, so an empty FIFO always
    // rejects the read. A full FIFO still accepts a write when a read frees
    // a slot in the same cycle.
    always_comb begin
        isFull   = (count_q == FULL_COUNT);
        isEmpty  = (count_q == '0);
        rdAccept = top_rd_en && !isEmpty;
        wrAccept = top_wr_en && (!isFull || rdAccept);
    end

    // Next-state for the pointers, occupancy, read port and error pulses.
    // The read data keeps its last value when no read is accepted.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        rdData_d    = rdData_q;
        valid_d     = 1'b0;
        overflow_d  = top_wr_en && isFull && !rdAccept;
        underflow_d = top_rd_en && isEmpty;

        if (wrAccept) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end

        if (rdAccept) begin
            rdPtr_d  = rdPtr_q + AW'(1);
            rdData_d = mem[rdPtr_q];
            valid_d  = 1'b1;
        end

        case ({wrAccept, rdAccept})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: the hardware reset acts asynchronously, the software
    // reset wins over everything else at the clock edge.
    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            rdData_q    <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (sw_rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            rdData_q    <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            rdData_q    <= rdData_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array has no reset. A write is dropped when the software reset
    // is active in the same cycle.
    always_ff @(posedge clk) begin
        if (wrAccept && !sw_rst) begin
            mem[wrPtr_q] <= top_wr_data;
        end
    end

    // Status levels. Thresholds are compared as unsigned 32-bit values, so a
    // threshold above DEPTH keeps almost_full low.
    always_comb begin
        ext_mem_full  = isFull;
        ext_mem_empty = isEmpty;
        enq_fifo_full = isFull;
        almost_full   = (32'(count_q) >= almost_full_value);
        almost_empty  = (32'(count_q) <= almost_empty_value);
        top_rd_data   = rdData_q;
        valid         = valid_q;
        overflow      = overflow_q;
        underflow     = underflow_q;
    end

endmodule

// File: tb/tb_sync_fifo_modport.sv
// Self-checking bench for sync_fifo_modport. The reference model is a word
// queue plus the expected read-port registers and error pulses. Directed
// scenarios are followed by phases of randomized traffic.

module tb_sync_fifo_modport;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              hw_rst;
    logic              sw_rst;
    logic              top_wr_en;
    logic [DATA_W-1:0] top_wr_data;
    logic              top_rd_en;
    logic [DATA_W-1:0] top_rd_data;
    logic [31:0]       almost_full_value;
    logic [31:0]       almost_empty_value;
    logic              enq_fifo_full;
    logic              valid;
    logic              almost_full;
    logic              almost_empty;
    logic              ext_mem_full;
    logic              ext_mem_empty;
    logic              overflow;
    logic              underflow;

    sync_fifo_modport #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .hw_rst             (hw_rst),
        .sw_rst             (sw_rst),
        .top_wr_en          (top_wr_en),
        .top_wr_data        (top_wr_data),
        .top_rd_en          (top_rd_en),
        .top_rd_data        (top_rd_data),
        .almost_full_value  (almost_full_value),
        .almost_empty_value (almost_empty_value),
        .enq_fifo_full      (enq_fifo_full),
        .valid              (valid),
        .almost_full        (almost_full),
        .almost_empty       (almost_empty),
        .ext_mem_full       (ext_mem_full),
        .ext_mem_empty      (ext_mem_empty),
        .overflow           (overflow),
        .underflow          (underflow)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] modelQ [$];
    logic [DATA_W-1:0] expData;
    logic              expValid;
    logic              expOverflow;
    logic              expUnderflow;

    // Count one comparison and report it when the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Empty the model and return the read port and pulses to reset values.
    task automatic clearModel();
        modelQ.delete();
        expData      = '0;
        expValid     = 1'b0;
        expOverflow  = 1'b0;
        expUnderflow = 1'b0;
    endtask

    // Apply one clock edge's worth of FIFO behaviour to the model.
    task automatic modelStep(input logic wr, input logic [DATA_W-1:0] d,
                             input logic rd, input logic sr);
        bit wasFull;
        bit wasEmpty;
        bit rdOk;
        bit wrOk;
        if (sr) begin
            clearModel();
        end else begin
            wasFull  = (modelQ.size() == DEPTH);
            wasEmpty = (modelQ.size() == 0);
            rdOk     = rd && !wasEmpty;
            wrOk     = wr && (!wasFull || rdOk);
            expValid = rdOk;
            if (rdOk) expData = modelQ.pop_front();
            if (wrOk) modelQ.push_back(d);
            expOverflow  = wr && !wrOk;
            expUnderflow = rd && wasEmpty;
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkAll();
        int n;
        n = modelQ.size();
        checkOutput("top_rd_data",   top_rd_data,           expData);
        checkOutput("valid",         32'(valid),            32'(expValid));
        checkOutput("ext_mem_full",  32'(ext_mem_full),     32'(n == DEPTH));
        checkOutput("enq_fifo_full", 32'(enq_fifo_full),    32'(n == DEPTH));
        checkOutput("ext_mem_empty", 32'(ext_mem_empty),    32'(n == 0));
        checkOutput("almost_full",   32'(almost_full),      32'(32'(n) >= almost_full_value));
        checkOutput("almost_empty",  32'(almost_empty),     32'(32'(n) <= almost_empty_value));
        checkOutput("overflow",      32'(overflow),         32'(expOverflow));
        checkOutput("underflow",     32'(underflow),        32'(expUnderflow));
    endtask

    // Drive one cycle of inputs from a falling edge, advance the model at the
    // rising edge and check all outputs at the next falling edge.
    task automatic applyStimulus(input logic wr, input logic [DATA_W-1:0] d,
                                 input logic rd, input logic sr);
        top_wr_en   = wr;
        top_wr_data = d;
        top_rd_en   = rd;
        sw_rst      = sr;
        @(posedge clk);
        modelStep(wr, d, rd, sr);
        @(negedge clk);
        checkAll();
    endtask

    // Asynchronous hardware reset in the middle of a cycle, held for one edge.
    task automatic hwResetPulse();
        top_wr_en = 1'b0;
        top_rd_en = 1'b0;
        sw_rst    = 1'b0;
        #2;
        hw_rst = 1'b1;
        #1;
        clearModel();
        checkAll();
        @(posedge clk);
        @(negedge clk);
        checkAll();
        hw_rst = 1'b0;
    endtask

    initial begin
        int wrPct;
        int rdPct;
        hw_rst             = 1'b1;
        sw_rst             = 1'b0;
        top_wr_en          = 1'b0;
        top_wr_data        = '0;
        top_rd_en          = 1'b0;
        almost_full_value  = 32'd12;
        almost_empty_value = 32'd3;
        clearModel();

        // Reset values with afv=12, aev=3.
        @(negedge clk);
        checkAll();
        @(negedge clk);
        checkAll();
        hw_rst = 1'b0;

        // Write four words, read them back in order with one-cycle latency.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hA5A5_0001 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("seq_data",  top_rd_data, 32'hA5A5_0001 + 32'(i));
            checkOutput("seq_valid", 32'(valid), 32'd1);
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("seq_empty", 32'(ext_mem_empty), 32'd1);

        // Fill, overflow with a 17th word, then drain only the first 16.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
        checkOutput("fill_full", 32'(ext_mem_full), 32'd1);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checkOutput("ovf_pulse", 32'(overflow), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("ovf_drop", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("drain_data", top_rd_data, 32'hB000_0000 + 32'(i));
        end

        // Full with simultaneous read and write: both accepted, no overflow.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC000_00FF, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Underflow on empty, then read and write together on empty.
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("unf_pulse", 32'(underflow), 32'd1);
        applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        checkOutput("unf_simul", 32'(underflow), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("simul_data", top_rd_data, 32'h1234_5678);

        // Pointer wrap: 10 writes, 10 reads, 10 writes, 10 reads.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput("wrap_data", top_rd_data, 32'hE000_0000 + 32'(i));
        end

        // Software reset with a write pending: the write is ignored.
        applyStimulus(1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h7777_0000, 1'b0, 1'b1);
        checkOutput("swrst_empty", 32'(ext_mem_empty), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);

        // Threshold corner values: zero and above DEPTH.
        almost_full_value  = 32'd0;
        almost_empty_value = 32'd0;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("afv_zero", 32'(almost_full), 32'd1);
        almost_full_value = 32'd17;
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
        checkOutput("afv_big", 32'(almost_full), 32'd0);
        hwResetPulse();

        // Randomized traffic with varying read/write bias, thresholds and resets.
        for (int phase = 0; phase < 8; phase++) begin
            wrPct = (phase % 2 == 0) ? 70 : 30;
            rdPct = 100 - wrPct;
            if (phase >= 6) begin
                wrPct = 50;
                rdPct = 50;
            end
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 31) == 0) begin
                    almost_full_value  = 32'($urandom_range(0, 20));
                    almost_empty_value = 32'($urandom_range(0, 18));
                end
                applyStimulus(32'($urandom_range(0, 99)) < 32'(wrPct), $urandom,
                              32'($urandom_range(0, 99)) < 32'(rdPct),
                              $urandom_range(0, 99) == 0);
            end
            hwResetPulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
